// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller
//   Generates a 4-bit duty level for a downstream PWM. A prescaler divides the
//   clock into duty "steps" (tick). Depending on mode the duty either follows
//   manualDuty, is forced to 0, breathes (ramp up, hold, ramp down, hold), or
//   blinks between 15 and 0.
//
// Parameters
//   STEP_DIV   : clock cycles per duty step (>= 2)
//   HOLD_STEPS : steps spent at each duty extreme (1..255)
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   mode       : 00 manual, 01 breathe, 10 blink, 11 off
//   manualDuty : duty level used in manual mode
//   pause      : freezes the prescaler and suppresses ticks
//   duty       : registered duty level
//   rising     : breathe mode and ramping up
//   peakPulse  : one-cycle registered pulse on each entry to HOLD_HI
module pwm_fade_controller #(
    parameter int STEP_DIV   = 1500000,
    parameter int HOLD_STEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] manualDuty,
    input  logic       pause,
    output logic [3:0] duty,
    output logic       rising,
    output logic       peakPulse
);

    localparam int CW = $clog2(STEP_DIV);

    localparam logic [1:0] M_MAN = 2'b00;
    localparam logic [1:0] M_BRE = 2'b01;
    localparam logic [1:0] M_BLK = 2'b10;
    localparam logic [1:0] M_OFF = 2'b11;

    localparam logic [CW-1:0] PRE_LAST  = CW'(STEP_DIV - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HI   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LO   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    duty_q,  duty_d;
    logic [7:0]    hold_q,  hold_d;
    logic [CW-1:0] pre_q,   pre_d;
    logic [1:0]    mode_q,  mode_d;
    logic          peak_q,  peak_d;
    logic          tick;

    assign tick = !pause && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        peak_d  = 1'b0;

        if (mode != mode_q) begin
            // Mode change wins over a coincident tick and restarts step timing.
            mode_d = mode;
            pre_d  = '0;
            hold_d = '0;
            unique case (mode)
                M_BRE: state_d = RAMP_UP;
                M_BLK: begin
                    state_d = HOLD_HI;
                    duty_d  = 4'd15;
                    peak_d  = 1'b1;
                end
                M_MAN: begin
                    state_d = HOLD_LO;
                    duty_d  = manualDuty;
                end
                default: begin
                    state_d = HOLD_LO;
                    duty_d  = 4'd0;
                end
            endcase
        end else begin
            if (!pause)
                pre_d = tick ? '0 : pre_q + 1'b1;

            unique case (mode_q)
                M_MAN: duty_d = manualDuty;
                M_OFF: duty_d = 4'd0;
                M_BRE: begin
                    if (tick) begin
                        unique case (state_q)
                            RAMP_UP: begin
                                if (duty_q != 4'd15) begin
                                    duty_d = duty_q + 4'd1;
                                end else begin
                                    state_d = HOLD_HI;
                                    hold_d  = '0;
                                    peak_d  = 1'b1;
                                end
                            end
                            HOLD_HI: begin
                                if (hold_q == HOLD_LAST) begin
                                    state_d = RAMP_DOWN;
                                    hold_d  = '0;
                                end else begin
                                    hold_d = hold_q + 8'd1;
                                end
                            end
                            RAMP_DOWN: begin
                                if (duty_q != 4'd0) begin
                                    duty_d = duty_q - 4'd1;
                                end else begin
                                    state_d = HOLD_LO;
                                    hold_d  = '0;
                                end
                            end
                            default: begin
                                if (hold_q == HOLD_LAST) begin
                                    state_d = RAMP_UP;
                                    hold_d  = '0;
                                end else begin
                                    hold_d = hold_q + 8'd1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // Blink only alternates between the two hold states.
                    if (tick) begin
                        if (state_q == HOLD_HI) begin
                            if (hold_q == HOLD_LAST) begin
                                state_d = HOLD_LO;
                                duty_d  = 4'd0;
                                hold_d  = '0;
                            end else begin
                                hold_d = hold_q + 8'd1;
                            end
                        end else if (state_q == HOLD_LO && hold_q != HOLD_LAST) begin
                            hold_d = hold_q + 8'd1;
                        end else begin
                            state_d = HOLD_HI;
                            duty_d  = 4'd15;
                            hold_d  = '0;
                            peak_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RAMP_UP;
            duty_q  <= 4'd0;
            hold_q  <= '0;
            pre_q   <= '0;
            mode_q  <= M_BRE;
            peak_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            peak_q  <= peak_d;
        end
    end

    assign duty      = duty_q;
    assign peakPulse = peak_q;
    assign rising    = (mode_q == M_BRE) && (state_q == RAMP_UP);

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Testbench for pwm_fade_controller (STEP_DIV=4, HOLD_STEPS=2).
// Stimulus pushes the expected outputs for each edge into a queue; a monitor
// pops and compares one entry per clock shortly after the rising edge.
module tb_pwm_fade_controller;

    localparam int SD = 4;
    localparam int HS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] manualDuty;
    logic       pause;
    logic [3:0] duty;
    logic       rising;
    logic       peakPulse;

    pwm_fade_controller #(.STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
        .clk(clk), .reset(reset), .mode(mode), .manualDuty(manualDuty),
        .pause(pause), .duty(duty), .rising(rising), .peakPulse(peakPulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic       r;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   done    = 0;

    // Reference model: duty level, ramp direction, and ticks left in a hold
    // (0 means ramping in breathe). Blink toggles the level every HS ticks.
    int m_duty, m_dir, m_left, m_pre, m_mode, m_pk;

    task automatic model(input bit r, input int m, input int md, input bit p);
        bit tk;
        if (r) begin
            m_duty = 0; m_dir = 1; m_left = 0; m_pre = 0; m_mode = 1; m_pk = 0;
        end else if (m != m_mode) begin
            m_mode = m; m_pre = 0; m_pk = 0;
            if (m == 1) begin
                m_dir = 1; m_left = 0;
            end else if (m == 2) begin
                m_duty = 15; m_left = HS; m_pk = 1;
            end else begin
                m_duty = (m == 0) ? md : 0; m_left = 0;
            end
        end else begin
            m_pk = 0;
            tk = !p && (m_pre == SD - 1);
            if (!p) m_pre = (m_pre + 1) % SD;
            if (m == 0) m_duty = md;
            else if (m == 3) m_duty = 0;
            else if (tk && m == 2) begin
                m_left--;
                if (m_left == 0) begin
                    m_duty = (m_duty == 15) ? 0 : 15;
                    m_left = HS;
                    m_pk = (m_duty == 15);
                end
            end else if (tk) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_dir = -m_dir;
                end else if (m_duty == (m_dir > 0 ? 15 : 0)) begin
                    m_left = HS;
                    m_pk = (m_dir > 0);
                end else begin
                    m_duty += m_dir;
                end
            end
        end
    endtask

    task automatic drive(input bit r, input int m, input int md, input bit p);
        exp_t e;
        @(negedge clk);
        reset = r; mode = 2'(m); manualDuty = 4'(md); pause = p;
        model(r, m, md, p);
        e.d = 4'(m_duty);
        e.r = (m_mode == 1) && (m_left == 0) && (m_dir > 0);
        e.p = m_pk[0];
        q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (duty !== e.d || rising !== e.r || peakPulse !== e.p) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got duty=%0d rising=%b peak=%b, want duty=%0d rising=%b peak=%b",
                             $time, duty, rising, peakPulse, e.d, e.r, e.p);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; mode = 2'b01; manualDuty = 4'd0; pause = 1'b0;
        // reset and a full breathe cycle
        repeat (3) drive(1, 1, 0, 0);
        repeat (170) drive(0, 1, 0, 0);
        // pause bursts during the ramp
        repeat (3) begin
            repeat (7) drive(0, 1, 0, 0);
            repeat (10) drive(0, 1, 0, 1);
        end
        // manual, pause has no effect
        repeat (3) drive(0, 0, 9, 0);
        repeat (3) drive(0, 0, 3, 1);
        repeat (2) drive(0, 0, 15, 0);
        // blink
        repeat (40) drive(0, 2, 0, 0);
        // off
        repeat (4) drive(0, 3, 5, 0);
        // breathe into ramp-down, then a one-cycle reset
        repeat (110) drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        repeat (20) drive(0, 1, 0, 0);
        // random traffic
        begin
            int m = 1;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 29) == 0) m = $urandom_range(0, 3);
                drive($urandom_range(0, 299) == 0, m, $urandom_range(0, 15),
                      $urandom_range(0, 7) == 0);
            end
        end
        repeat (3) @(negedge clk);
        done = 1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
